// File: rtl/sift_sram_pkg.sv
// rtl/sift_sram_pkg.sv - shared SRAM arbiter/client widths and read streamer state encoding
package sift_sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 32;
  localparam int PIX_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } stream_state_e;

  // Byte 0 is the least significant byte of the SRAM word.
  function automatic logic [PIX_W-1:0] word_byte(input logic [SRAM_DATA_W-1:0] word,
                                                 input logic [1:0]             idx);
    return word[{idx, 3'b000} +: PIX_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty/count, push and pop legal together at any occupancy
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/sram_read_streamer.sv
// rtl/sram_read_streamer.sv - issues sequential SRAM word reads and unpacks responses into an 8-bit pixel stream
module sram_read_streamer
  import sift_sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = SRAM_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_W-1:0]      req_addr,
  input  logic                   resp_valid,
  output logic                   resp_ready,
  input  logic [SRAM_DATA_W-1:0] resp_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIX_W-1:0]       pix_data
);

  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);

  stream_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] words_left_q, words_left_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;

  logic                   req_fire;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [SRAM_DATA_W-1:0] fifo_head;
  logic [CW-1:0]          fifo_count;

  sync_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_valid),
    .push_data (resp_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    credits_d    = credits_q;
    byte_idx_d   = byte_idx_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    fifo_pop     = 1'b0;

    req_valid = (state_q == ST_ISSUE) && (credits_q != '0) && (words_left_q != '0);
    req_fire  = req_valid && req_ready;

    // The output register refills whenever it is empty or being taken; the head word
    // retires (and returns its credit) as its last byte moves into the register.
    if (!pix_valid_q || pix_ready) begin
      pix_valid_d = !fifo_empty;
      if (!fifo_empty) begin
        pix_data_d = word_byte(fifo_head, byte_idx_q);
        byte_idx_d = byte_idx_q + 2'd1;
        fifo_pop   = (byte_idx_q == 2'd3);
      end
    end

    case ({req_fire, fifo_pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          words_left_d = word_count;
          state_d      = (word_count != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (req_fire) begin
          addr_d       = addr_q + ADDR_W'(1);
          words_left_d = words_left_q - ADDR_W'(1);
          if (words_left_q == ADDR_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (credits_q == FULL_CREDITS && fifo_count == '0 && !pix_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      credits_q    <= FULL_CREDITS;
      byte_idx_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      credits_q    <= credits_d;
      byte_idx_q   <= byte_idx_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign req_addr   = addr_q;
  assign resp_ready = 1'b1;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(resp_valid && fifo_full && !fifo_pop));
  a_no_idle_resp: assert property (@(posedge clock) disable iff (reset)
    !(resp_valid && state_q == ST_IDLE));
  a_credit_range: assert property (@(posedge clock) disable iff (reset)
    credits_q <= FULL_CREDITS);

endmodule

// File: tb/tb_sram_read_streamer.sv
// tb/tb_sram_read_streamer.sv - directed self-checking bench for sram_read_streamer
module tb_sram_read_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] base_addr;
  logic [17:0] word_count;
  logic        busy;
  logic        done;
  logic        req_valid;
  logic        req_ready;
  logic [17:0] req_addr;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = '0;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;

  int errors = 0;
  int checks = 0;

  int req_count  = 0;
  int pix_count  = 0;
  int done_count = 0;
  int req0, pix0, done0;

  logic [17:0] pend[$];
  logic [17:0] exp_addr[$];
  logic [7:0]  exp_pix[$];

  sram_read_streamer #(
    .FIFO_DEPTH (8),
    .ADDR_W     (18)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sram_word(input logic [17:0] a);
    case (a)
      18'h00010: return 32'hA3A2A1A0;
      18'h00011: return 32'hB3B2B1B0;
      default:   return {a[5:0], 2'd3, a[5:0], 2'd2, a[5:0], 2'd1, a[5:0], 2'd0};
    endcase
  endfunction

  // SRAM read port with one cycle of latency, plus stream monitors; all sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      pend.delete();
      resp_valid = 1'b0;
    end else begin
      if (pend.size() > 0) begin
        resp_data  = sram_word(pend.pop_front());
        resp_valid = 1'b1;
      end else begin
        resp_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        pend.push_back(req_addr);
        req_count++;
        check("req_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) check("req_addr", 32'(req_addr), 32'(exp_addr.pop_front()));
      end
      if (pix_valid && pix_ready) begin
        pix_count++;
        check("pix_expected", 32'(exp_pix.size() > 0), 32'd1);
        if (exp_pix.size() > 0) check("pix_data", 32'(pix_data), 32'(exp_pix.pop_front()));
      end
      if (done) done_count++;
    end
  end

  task automatic begin_stream(input logic [17:0] base, input logic [17:0] count);
    logic [17:0] a;
    logic [31:0] w;
    for (int i = 0; i < int'(count); i++) begin
      a = base + 18'(i);
      w = sram_word(a);
      exp_addr.push_back(a);
      for (int k = 0; k < 4; k++) exp_pix.push_back(w[k*8 +: 8]);
    end
    req0  = req_count;
    pix0  = pix_count;
    done0 = done_count;
    @(posedge clock); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic finish_stream(input string tag, input int count);
    for (int i = 0; i < 3000 && done_count == done0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_done_pulses"}, 32'(done_count - done0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_req_total"}, 32'(req_count - req0), 32'(count));
    check({tag, "_pix_total"}, 32'(pix_count - pix0), 32'(count * 4));
    check({tag, "_pix_left"}, 32'(exp_pix.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    check({tag, "_req_addr"}, 32'(req_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    req_ready  = 1'b1;
    pix_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    check("rst_resp_ready", 32'(resp_ready), 32'd1);
    reset = 1'b0;

    // basic two-word read
    begin_stream(18'h00010, 18'd2);
    finish_stream("basic", 2);

    // backpressure: credits cap outstanding reads at the FIFO depth
    pix_ready = 1'b0;
    begin_stream(18'h00104, 18'd20);
    repeat (30) @(posedge clock);
    #1;
    check("bp_req_capped", 32'(req_count - req0), 32'd8);
    check("bp_req_valid_low", 32'(req_valid), 32'd0);
    check("bp_pix_valid", 32'(pix_valid), 32'd1);
    check("bp_pix_held", 32'(pix_data), 32'h10);
    pix_ready = 1'b1;
    finish_stream("bp", 20);

    // address wrap
    begin_stream(18'h3FFFE, 18'd4);
    finish_stream("wrap", 4);

    // zero length goes straight to DONE
    begin_stream(18'h00055, 18'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_req_valid", 32'(req_valid), 32'd0);
    @(posedge clock); #1;
    check("zero_done_one_cycle", 32'(done), 32'd0);
    finish_stream("zero", 0);

    // start while busy is ignored
    begin_stream(18'h00020, 18'd6);
    repeat (2) @(posedge clock);
    #1;
    check("busy_during", 32'(busy), 32'd1);
    start      = 1'b1;
    base_addr  = 18'h00030;
    word_count = 18'd3;
    @(posedge clock); #1;
    start = 1'b0;
    finish_stream("busy_start", 6);

    // reset mid-run, then a fresh read from a new base
    begin_stream(18'h00040, 18'd10);
    for (int i = 0; i < 100 && (req_count - req0) < 3; i++) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_issued", 32'(req_count - req0), 32'd3);
    exp_addr.delete();
    exp_pix.delete();
    @(posedge clock); #1;
    check("midrst_no_done", 32'(done_count - done0), 32'd0);
    reset = 1'b0;
    begin_stream(18'h00080, 18'd5);
    finish_stream("post_rst", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
